regbank_write_arbiter: RTL and testbench
========================================

// Module: regbank_write_arbiter
// PURPOSE
// Shares the register bank's single write port (write_register/write_data/regwrite) between the
// pipeline write-back stage (WB) and the debug/loader unit (DBG). It arbitrates per cycle with
// WB priority and a DBG anti-starvation counter. A lock FSM drains and stalls the pipeline so DBG
// can own the port for bursts. Sits between the WB stage / debug unit and register_bank.
// PARAMETERS
// STARVE_MAX  4   consecutive cycles DBG may wait before it is force-granted one cycle (1..15)
// STAT_W      16  width of the optional statistics counters
// PORTS
// clk            in   1   rising-edge clock
// rst_n          in   1   asynchronous active-low reset
// wb_valid       in   1   WB write request
// wb_reg         in   5   WB destination register
// wb_data        in   32  WB write data
// wb_ready       out  1   WB request accepted this cycle (combinational)
// dbg_valid      in   1   DBG write request
// dbg_reg        in   5   DBG destination register
// dbg_data       in   32  DBG write data
// dbg_ready      out  1   DBG request accepted this cycle (combinational)
// dbg_lock_req   in   1   DBG asks for exclusive port ownership (level)
// dbg_lock_ack   out  1   exclusive ownership granted (registered)
// stall_pipe     out  1   pipeline must not issue new writers (registered)
// rb_write_reg   out  5   to register_bank.write_register
// rb_write_data  out  32  to register_bank.write_data
// rb_regwrite    out  1   to register_bank.regwrite
// BEHAVIOUR
// - Reset: state=NORMAL; starve_cnt=0; rb_regwrite=0; rb_write_reg=0; rb_write_data=0.
//   Also dbg_lock_ack=0, stall_pipe=0, stats=0. Reset is asynchronous and may assert mid-burst;
//   it discards any in-flight write.
// - A transfer occurs when valid&&ready. Exactly one requester is granted per cycle.
// - Grant in NORMAL/DRAIN: WB if wb_valid and starve_cnt<STARVE_MAX; otherwise DBG if dbg_valid.
// - Grant in LOCKED: DBG only; wb_ready=0.
// - starve_cnt behaviour:
//   - increments (saturating at STARVE_MAX) each cycle dbg_valid&&!dbg_ready;
//   - clears on any DBG transfer or when dbg_valid=0;
//   - at STARVE_MAX, DBG wins even if wb_valid=1.
// - Latency: a transfer in cycle N drives rb_* in cycle N+1. The register bank writes at the
//   end of N+1. rb_regwrite is high for exactly one cycle per transfer.
// - Writes to register 0: handshake completes, but rb_regwrite stays 0 (r0 is read-only zero).
//   rb_write_reg/rb_write_data still update.
// - No transfer: rb_regwrite=0; rb_write_reg/rb_write_data hold their previous values.
// - FSM:
//   - NORMAL->DRAIN when dbg_lock_req=1. stall_pipe=1 from the next cycle.
//   - DRAIN->LOCKED on the first cycle with wb_valid=0. dbg_lock_ack=1 from the next cycle.
//   - DRAIN->NORMAL if dbg_lock_req drops.
//   - LOCKED->NORMAL when dbg_lock_req=0. ack and stall_pipe drop on the next cycle.
//     A DBG transfer in that same cycle is still accepted.
// - stall_pipe is 1 in DRAIN and LOCKED.
// - dbg_lock_ack is 1 only in LOCKED.
// - Simultaneous wb_valid&&dbg_valid with starve_cnt<STARVE_MAX: WB wins and DBG's counter
//   advances.
// CONFIGURATION
// - REGARB_STATS_EN defined:
//   - adds outputs stat_wb_cnt, stat_dbg_cnt and stat_stall_cnt [STAT_W-1:0].
//   - stat_wb_cnt / stat_dbg_cnt count transfers per requester, r0 writes included.
//   - stat_stall_cnt counts cycles with stall_pipe=1.
//   - all saturate at all-ones and reset to 0.
// - REGARB_STATS_EN undefined: those ports and counters do not exist. All other behaviour is
//   identical.
// TESTING
// - wb_valid=1, wb_reg=5, wb_data=32'hDEADBEEF, dbg idle -> wb_ready=1; next cycle
//   rb_regwrite=1, rb_write_reg=5, rb_write_data=32'hDEADBEEF.
// - wb_valid and dbg_valid held 1 (STARVE_MAX=4) -> WB granted 4 cycles, DBG on the 5th;
//   starve_cnt returns to 0; repeating pattern.
// - dbg_valid=1, dbg_reg=0, dbg_data=32'h1 -> dbg_ready=1; next cycle rb_regwrite=0,
//   rb_write_reg=0.
// - dbg_lock_req=1 while wb_valid=1 for 3 cycles:
//   - stall_pipe=1 one cycle after the request; DRAIN persists until wb_valid=0; then
//     dbg_lock_ack=1;
//   - during LOCKED, wb_valid=1 -> wb_ready=0;
//   - drop the request -> ack=0 and stall_pipe=0 next cycle.
// - rst_n low mid-LOCKED with DBG transfer pending -> immediately rb_regwrite=0,
//   dbg_lock_ack=0, stall_pipe=0; after release, NORMAL and WB granted.
// - REGARB_STATS_EN: 3 WB and 2 DBG transfers plus 4 lock cycles -> stat_wb_cnt=3,
//   stat_dbg_cnt=2, stat_stall_cnt=4 (stall_pipe cycles); counters saturate at all-ones.

Source files
------------

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter
// Shares the register bank's single write port between the pipeline write-back
// stage (WB) and the debug/loader unit (DBG). WB has priority. A starvation
// counter force-grants DBG after STARVE_MAX consecutive refused cycles. A lock
// FSM (NORMAL -> DRAIN -> LOCKED) stalls the pipeline and lets DBG own the port.
// Optional build macro: REGARB_STATS_EN adds saturating transfer/stall counters.

module regbank_write_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned STAT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        dbg_valid,
    input  logic [4:0]  dbg_reg,
    input  logic [31:0] dbg_data,
    output logic        dbg_ready,
    input  logic        dbg_lock_req,
    output logic        dbg_lock_ack,
    output logic        stall_pipe,
    output logic [4:0]  rb_write_reg,
    output logic [31:0] rb_write_data,
    output logic        rb_regwrite
`ifdef REGARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_wb_cnt,
    output logic [STAT_W-1:0] stat_dbg_cnt,
    output logic [STAT_W-1:0] stat_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    if ((STARVE_MAX < 32'd1) || (STARVE_MAX > 32'd15)) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end
    if (STAT_W < 32'd1) begin : g_bad_stat_w
        $error("STAT_W must be at least 1");
    end

    lock_state_t state_r;
    lock_state_t state_nxt_s;
    logic [3:0]  starve_cnt_r;
    logic [3:0]  starve_nxt_s;
    logic        wb_grant_s;
    logic        dbg_grant_s;
    logic        xfer_s;
    logic [4:0]  xfer_reg_s;
    logic [31:0] xfer_data_s;

    // Per-cycle grant: DBG only while locked, otherwise WB first unless DBG is starved.
    always_comb begin
        wb_grant_s  = 1'b0;
        dbg_grant_s = 1'b0;
        if (state_r == ST_LOCKED) begin
            dbg_grant_s = dbg_valid;
        end else begin
            wb_grant_s  = wb_valid && (starve_cnt_r < STARVE_LIM);
            dbg_grant_s = dbg_valid && !wb_grant_s;
        end
        wb_ready  = wb_grant_s;
        dbg_ready = dbg_grant_s;
    end

    // Select the winning requester's register/data for the write port.
    always_comb begin
        xfer_s      = 1'b0;
        xfer_reg_s  = wb_reg;
        xfer_data_s = wb_data;
        if (wb_grant_s) begin
            xfer_s = 1'b1;
        end else if (dbg_grant_s) begin
            xfer_s      = 1'b1;
            xfer_reg_s  = dbg_reg;
            xfer_data_s = dbg_data;
        end else begin
            xfer_s = 1'b0;
        end
    end

    // Starvation counter: count refused DBG cycles, clear on DBG transfer or idle DBG.
    always_comb begin
        starve_nxt_s = 4'd0;
        if (dbg_valid && !dbg_grant_s) begin
            if (starve_cnt_r >= STARVE_LIM) begin
                starve_nxt_s = STARVE_LIM;
            end else begin
                starve_nxt_s = starve_cnt_r + 4'd1;
            end
        end else begin
            starve_nxt_s = 4'd0;
        end
    end

    // Lock FSM next state: a dropped request always wins over drain completion.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_NORMAL: begin
                if (dbg_lock_req) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_NORMAL;
                end
            end
            ST_DRAIN: begin
                if (!dbg_lock_req) begin
                    state_nxt_s = ST_NORMAL;
                end else if (!wb_valid) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_LOCKED: begin
                if (!dbg_lock_req) begin
                    state_nxt_s = ST_NORMAL;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: state_nxt_s = ST_NORMAL;
        endcase
    end

    // FSM state, starvation counter and registered lock status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_NORMAL;
            starve_cnt_r <= 4'd0;
            stall_pipe   <= 1'b0;
            dbg_lock_ack <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            stall_pipe   <= (state_nxt_s != ST_NORMAL);
            dbg_lock_ack <= (state_nxt_s == ST_LOCKED);
        end
    end

    // Register-bank write port: one-cycle strobe per transfer, r0 writes suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_regwrite   <= 1'b0;
            rb_write_reg  <= 5'd0;
            rb_write_data <= 32'd0;
        end else if (xfer_s) begin
            rb_regwrite   <= (xfer_reg_s != 5'd0);
            rb_write_reg  <= xfer_reg_s;
            rb_write_data <= xfer_data_s;
        end else begin
            rb_regwrite   <= 1'b0;
        end
    end

`ifdef REGARB_STATS_EN
    logic [STAT_W-1:0] stat_wb_r;
    logic [STAT_W-1:0] stat_dbg_r;
    logic [STAT_W-1:0] stat_stall_r;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Saturating statistics: transfers per requester and stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wb_r    <= {STAT_W{1'b0}};
            stat_dbg_r   <= {STAT_W{1'b0}};
            stat_stall_r <= {STAT_W{1'b0}};
        end else begin
            if (wb_grant_s) begin
                stat_wb_r <= sat_inc(stat_wb_r);
            end
            if (dbg_grant_s) begin
                stat_dbg_r <= sat_inc(stat_dbg_r);
            end
            if (stall_pipe) begin
                stat_stall_r <= sat_inc(stat_stall_r);
            end
        end
    end

    assign stat_wb_cnt    = stat_wb_r;
    assign stat_dbg_cnt   = stat_dbg_r;
    assign stat_stall_cnt = stat_stall_r;
`else
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench for regbank_write_arbiter: a driver issues stimulus each cycle and
// pushes the reference model's expectations; a monitor pops and compares them.

module tb_regbank_write_arbiter;

    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned STAT_W     = 5;
    localparam int          STAT_MAX   = (1 << STAT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_reg = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        wb_ready;
    logic        dbg_valid = 1'b0;
    logic [4:0]  dbg_reg = 5'd0;
    logic [31:0] dbg_data = 32'd0;
    logic        dbg_ready;
    logic        dbg_lock_req = 1'b0;
    logic        dbg_lock_ack;
    logic        stall_pipe;
    logic [4:0]  rb_write_reg;
    logic [31:0] rb_write_data;
    logic        rb_regwrite;
`ifdef REGARB_STATS_EN
    logic [STAT_W-1:0] stat_wb_cnt;
    logic [STAT_W-1:0] stat_dbg_cnt;
    logic [STAT_W-1:0] stat_stall_cnt;
`endif

    always #5 clk = ~clk;

    regbank_write_arbiter #(
        .STARVE_MAX(STARVE_MAX),
        .STAT_W    (STAT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .wb_ready     (wb_ready),
        .dbg_valid    (dbg_valid),
        .dbg_reg      (dbg_reg),
        .dbg_data     (dbg_data),
        .dbg_ready    (dbg_ready),
        .dbg_lock_req (dbg_lock_req),
        .dbg_lock_ack (dbg_lock_ack),
        .stall_pipe   (stall_pipe),
        .rb_write_reg (rb_write_reg),
        .rb_write_data(rb_write_data),
`ifdef REGARB_STATS_EN
        .rb_regwrite  (rb_regwrite),
        .stat_wb_cnt  (stat_wb_cnt),
        .stat_dbg_cnt (stat_dbg_cnt),
        .stat_stall_cnt(stat_stall_cnt)
`else
        .rb_regwrite  (rb_regwrite)
`endif
    );

    typedef struct {
        logic        is_rst;
        logic        act_wbr;
        logic        act_dbr;
        logic        exp_wbr;
        logic        exp_dbr;
        logic        exp_we;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        logic        exp_stall;
        logic        exp_ack;
        int          exp_swb;
        int          exp_sdbg;
        int          exp_sstall;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  finish_req = 1'b0;

    // Reference model: phase 0 = free, 1 = draining, 2 = locked.
    int          m_phase = 0;
    int          m_refused = 0;
    logic [4:0]  m_reg = 5'd0;
    logic [31:0] m_data = 32'd0;
    int          m_swb = 0;
    int          m_sdbg = 0;
    int          m_sstall = 0;

    function automatic int sat(input int v);
        return (v >= STAT_MAX) ? STAT_MAX : v + 1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_refused = 0; m_reg = 5'd0; m_data = 32'd0;
        m_swb = 0; m_sdbg = 0; m_sstall = 0;
    endtask

    task automatic step(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                        input logic dv, input logic [4:0] dr, input logic [31:0] dd,
                        input logic lk);
        item_t it;
        logic  wb_win, dbg_win, we;
        @(negedge clk);
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        dbg_valid = dv; dbg_reg = dr; dbg_data = dd; dbg_lock_req = lk;
        #1;
        it.is_rst  = 1'b0;
        it.act_wbr = wb_ready;
        it.act_dbr = dbg_ready;
        wb_win  = wv && (m_phase != 2) && (m_refused < int'(STARVE_MAX));
        dbg_win = dv && !wb_win;
        we = 1'b0;
        if (wb_win) begin
            m_reg = wr; m_data = wd; we = (wr != 5'd0); m_swb = sat(m_swb);
        end else if (dbg_win) begin
            m_reg = dr; m_data = dd; we = (dr != 5'd0); m_sdbg = sat(m_sdbg);
        end
        if (m_phase != 0) m_sstall = sat(m_sstall);
        m_refused = (dv && !dbg_win) ? ((m_refused + 1 > int'(STARVE_MAX)) ? int'(STARVE_MAX) : m_refused + 1) : 0;
        if (m_phase == 0)      m_phase = lk ? 1 : 0;
        else if (m_phase == 1) m_phase = !lk ? 0 : (!wv ? 2 : 1);
        else                   m_phase = lk ? 2 : 0;
        it.exp_wbr    = wb_win;
        it.exp_dbr    = dbg_win;
        it.exp_we     = we;
        it.exp_reg    = m_reg;
        it.exp_data   = m_data;
        it.exp_stall  = (m_phase != 0);
        it.exp_ack    = (m_phase == 2);
        it.exp_swb    = m_swb;
        it.exp_sdbg   = m_sdbg;
        it.exp_sstall = m_sstall;
        exp_q.push_back(it);
    endtask

    // Assert reset mid-cycle; the outputs must clear at once, without a clock edge.
    task automatic do_reset(input logic dv, input logic lk);
        item_t it;
        @(negedge clk);
        wb_valid = 1'b0; dbg_valid = dv; dbg_reg = 5'd9; dbg_data = 32'h1234_5678;
        dbg_lock_req = lk;
        #1;
        it.is_rst  = 1'b1;
        it.act_wbr = wb_ready;
        it.act_dbr = dbg_ready;
        it.exp_wbr = 1'b0;
        it.exp_dbr = dv;
        model_reset();
        it.exp_we = 1'b0; it.exp_reg = 5'd0; it.exp_data = 32'd0;
        it.exp_stall = 1'b0; it.exp_ack = 1'b0;
        it.exp_swb = 0; it.exp_sdbg = 0; it.exp_sstall = 0;
        exp_q.push_back(it);
        #1 rst_n = 1'b0;
        #2;
        wb_valid = 1'b0; dbg_valid = 1'b0; dbg_lock_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: after each clock edge (or asynchronous reset) compare against the queue head.
    initial begin
        item_t it;
        while (!finish_req) begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                chk(it.is_rst ? "rst_wb_ready" : "wb_ready", 32'(it.act_wbr), 32'(it.exp_wbr));
                chk(it.is_rst ? "rst_dbg_ready" : "dbg_ready", 32'(it.act_dbr), 32'(it.exp_dbr));
                chk("rb_regwrite", 32'(rb_regwrite), 32'(it.exp_we));
                chk("rb_write_reg", 32'(rb_write_reg), 32'(it.exp_reg));
                chk("rb_write_data", rb_write_data, it.exp_data);
                chk("stall_pipe", 32'(stall_pipe), 32'(it.exp_stall));
                chk("dbg_lock_ack", 32'(dbg_lock_ack), 32'(it.exp_ack));
`ifdef REGARB_STATS_EN
                chk("stat_wb_cnt", 32'(stat_wb_cnt), 32'(it.exp_swb));
                chk("stat_dbg_cnt", 32'(stat_dbg_cnt), 32'(it.exp_sdbg));
                chk("stat_stall_cnt", 32'(stat_stall_cnt), 32'(it.exp_sstall));
`endif
            end
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Driver: directed scenarios first, then randomized traffic.
    initial begin
        logic lk;
        do_reset(1'b0, 1'b0);
        // Single WB write.
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        // Both requesting: WB four times, then DBG forced, repeating.
        for (int i = 0; i < 12; i++)
            step(1'b1, 5'(i + 1), 32'(i * 16), 1'b1, 5'd20, 32'hD000_0000 + 32'(i), 1'b0);
        // DBG write to r0.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        // Lock while WB busy for three cycles, then locked traffic, then release.
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd7, 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd8, 32'h200 + 32'(i), 1'b1, 5'd3, 32'h300 + 32'(i), 1'b1);
        step(1'b1, 5'd8, 32'h2FF, 1'b1, 5'd4, 32'h3FF, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        // Reset mid-LOCKED with a DBG transfer pending, then WB must be granted.
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hCAFE, 1'b1);
        do_reset(1'b1, 1'b1);
        step(1'b1, 5'd11, 32'hAAAA_5555, 1'b0, 5'd0, 32'd0, 1'b0);
        // Randomized traffic with a slowly toggling lock request.
        lk = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19, 0) == 0) lk = ~lk;
            step(($urandom_range(9, 0) < 7),
                 ($urandom_range(5, 0) == 0) ? 5'd0 : 5'($urandom),
                 32'($urandom),
                 ($urandom_range(1, 0) == 1),
                 ($urandom_range(5, 0) == 0) ? 5'd0 : 5'($urandom),
                 32'($urandom),
                 lk);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        finish_req = 1'b1;
    end

endmodule
